// File: rtl/arb_pkg.sv
// Shared widths, FSM state type and one-hot decode helper for the
// round-robin arbiter.
package arb_pkg;
  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // 3:8 decode of a grant index.
  function automatic logic [N_REQ-1:0] idx2onehot(input logic [IDX_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction
endpackage

// File: rtl/prio_enc8_3.sv
// 8:3 priority encoder: index of the lowest set bit plus an any-set flag.
module prio_enc8_3
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan from the top down so the lowest set bit wins.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = IDX_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arb_enc8.sv
// Registered 8-requester round-robin arbiter with encoded grant index and
// valid/ready handshake. Optional multi-beat lock: define RR_ARB_LOCK_EN.
module rr_arb_enc8
  import arb_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             gnt_ready,
`ifdef RR_ARB_LOCK_EN
  input  logic             lock,
`endif
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx,
  output logic [N_REQ-1:0] gnt_onehot
);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic [N_REQ-1:0] gnt_onehot_q, gnt_onehot_d;

  logic             hs;
  logic             lock_hold;
  logic [IDX_W-1:0] arb_ptr;
  logic [N_REQ-1:0] req_rot;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_any;
  logic [IDX_W-1:0] win_idx;

  assign hs = gnt_valid_q & gnt_ready;

`ifdef RR_ARB_LOCK_EN
  // Lock only holds ownership while the owner is still requesting.
  assign lock_hold = lock & req[gnt_idx_q];
`else
  assign lock_hold = 1'b0;
`endif

  // In GRANT the pointer used is the post-handshake one, so back-to-back
  // grants see the advanced priority without waiting for ptr_q to update.
  assign arb_ptr = (state_q == GRANT) ? IDX_W'(gnt_idx_q + 1'b1) : ptr_q;

  // Rotate req right by arb_ptr so bit 0 is the highest-priority requester.
  always_comb begin
    req_rot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_rot[i] = req[IDX_W'(arb_ptr + IDX_W'(i))];
    end
  end

  prio_enc8_3 u_enc (
    .vec (req_rot),
    .idx (enc_idx),
    .any (enc_any)
  );

  assign win_idx = IDX_W'(enc_idx + arb_ptr);

  // Next-state / next-grant logic; everything holds unless an event occurs.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    gnt_valid_d  = gnt_valid_q;
    gnt_idx_d    = gnt_idx_q;
    gnt_onehot_d = gnt_onehot_q;
    case (state_q)
      IDLE: begin
        if (enc_any) begin
          state_d      = GRANT;
          gnt_valid_d  = 1'b1;
          gnt_idx_d    = win_idx;
          gnt_onehot_d = idx2onehot(win_idx);
        end
      end
      GRANT: begin
        if (hs && !lock_hold) begin
          ptr_d = IDX_W'(gnt_idx_q + 1'b1);
          if (enc_any) begin
            gnt_idx_d    = win_idx;
            gnt_onehot_d = idx2onehot(win_idx);
          end else begin
            state_d      = IDLE;
            gnt_valid_d  = 1'b0;
            gnt_onehot_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset that discards any pending grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      gnt_valid_q  <= 1'b0;
      gnt_idx_q    <= '0;
      gnt_onehot_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      gnt_valid_q  <= gnt_valid_d;
      gnt_idx_q    <= gnt_idx_d;
      gnt_onehot_q <= gnt_onehot_d;
    end
  end

  assign gnt_valid  = gnt_valid_q;
  assign gnt_idx    = gnt_idx_q;
  assign gnt_onehot = gnt_onehot_q;

endmodule

// File: tb/tb_rr_arb_enc8.sv
// Directed bench for rr_arb_enc8 (lock test enabled with RR_ARB_LOCK_EN).
module tb_rr_arb_enc8;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] req;
  logic       gnt_ready;
  logic       lock;
  logic       gnt_valid;
  logic [2:0] gnt_idx;
  logic [7:0] gnt_onehot;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rr_arb_enc8 dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .gnt_ready  (gnt_ready),
`ifdef RR_ARB_LOCK_EN
    .lock       (lock),
`endif
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx),
    .gnt_onehot (gnt_onehot)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_gnt(input string tag, input logic v, input logic [2:0] idx,
                         input logic [7:0] oh);
    chk({tag, ".valid"},  32'(gnt_valid),  32'(v));
    chk({tag, ".idx"},    32'(gnt_idx),    32'(idx));
    chk({tag, ".onehot"}, 32'(gnt_onehot), 32'(oh));
  endtask

  initial begin
    logic [2:0] alt [4];
    alt = '{3'd2, 3'd4, 3'd2, 3'd4};
    reset = 1'b1; req = '0; gnt_ready = 1'b0; lock = 1'b0;
    tick();
    chk_gnt("reset", 1'b0, 3'd0, 8'h00);
    reset = 1'b0;

    // Idle with no requests; ready high must be ignored.
    gnt_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_gnt($sformatf("idle%0d", i), 1'b0, 3'd0, 8'h00);
    end

    // Two requesters alternate with no bubble.
    req = 8'b0001_0100;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_gnt($sformatf("alt%0d", i), 1'b1, alt[i], 8'h01 << alt[i]);
    end
    req = 8'h00;
    tick();
    chk_gnt("alt_drain", 1'b0, 3'd4, 8'h00);

    // Sticky grant on 7 while the request drops and ready is low.
    gnt_ready = 1'b0;
    req = 8'h80;
    tick();
    chk_gnt("hold0", 1'b1, 3'd7, 8'h80);
    req = 8'h00;
    for (int i = 1; i < 4; i++) begin
      tick();
      chk_gnt($sformatf("hold%0d", i), 1'b1, 3'd7, 8'h80);
    end
    gnt_ready = 1'b1;
    tick();
    chk_gnt("hold_hs", 1'b0, 3'd7, 8'h00);

    // Full request: rotation from the wrapped pointer 0.
    req = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk_gnt($sformatf("rot%0d", i), 1'b1, 3'(i % 8), 8'h01 << (i % 8));
    end

    // Handshake on 0 moves to the only requester 3, then reset mid-grant.
    req = 8'h08;
    tick();
    chk_gnt("pend3", 1'b1, 3'd3, 8'h08);
    gnt_ready = 1'b0;
    reset = 1'b1;
    tick();
    chk_gnt("rst_mid", 1'b0, 3'd0, 8'h00);
    reset = 1'b0;
    tick();
    chk_gnt("post_rst", 1'b1, 3'd3, 8'h08);

`ifdef RR_ARB_LOCK_EN
    // Owner 3 is not requesting, so lock is ignored and rotation picks 0.
    req = 8'h03; lock = 1'b1; gnt_ready = 1'b1;
    tick();
    chk_gnt("lock_skip", 1'b1, 3'd0, 8'h01);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_gnt($sformatf("lock%0d", i), 1'b1, 3'd0, 8'h01);
    end
    lock = 1'b0;
    tick();
    chk_gnt("unlock", 1'b1, 3'd1, 8'h02);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/rr_arb_enc8.md
# rr_arb_enc8

Registered 8-requester round-robin arbiter whose core is an 8:3 priority encoder: the inverse of the 3:8 decoder path. It converts a request vector into a 3-bit grant index plus matching one-hot grant. The grant is held under a valid/ready handshake until the consumer accepts it. It sits in front of shared pipeline resources (register-file write port, memory port) where several stages contend and the winner must be presented as an encoded index.

## Interface
Parameters:
- none; widths come from the shared package (N_REQ = 8, IDX_W = 3)

Ports:
- clk  input  1  single clock; all state updates on posedge
- reset  input  1  synchronous, active-high
- req  input  8  request vector; bit i = requester i
- gnt_ready  input  1  consumer accepts the current grant this cycle
- gnt_valid  output  1  grant outputs are valid
- gnt_idx  output  3  encoded index of the granted requester
- gnt_onehot  output  8  one-hot of gnt_idx when gnt_valid=1, else 0
- lock  input  1  present only with RR_ARB_LOCK_EN; see Configuration

## Operation
- State: ptr[2:0] (highest-priority index), FSM {IDLE, GRANT}.
- Winner selection is combinational. It picks the first set bit of req, scanning ptr, ptr+1, … ptr+7, wrapping mod 8.
- IDLE:
  - if req != 0: register winner into gnt_idx and gnt_onehot, set gnt_valid=1, go to GRANT.
  - else stay in IDLE, gnt_valid=0.
- GRANT, no handshake (gnt_ready=0): gnt_idx, gnt_onehot and gnt_valid hold stable, even if req changes or the granted bit drops. Grants are sticky and never retracted.
- GRANT, handshake (gnt_valid & gnt_ready):
  - ptr <= gnt_idx + 1, wrapping 7 -> 0.
  - Next winner is computed from current req using the updated ptr value, computed combinationally.
  - If req != 0, the next grant is registered in the same cycle (back-to-back, no bubble) and the FSM stays in GRANT.
  - Otherwise gnt_valid <= 0, gnt_onehot <= 0, and the FSM goes to IDLE. gnt_idx keeps its last value.
- A just-granted requester still asserting req gets lowest priority on the next arbitration.
- gnt_onehot is always exactly the decode of gnt_idx while gnt_valid=1 (invariant).

## Timing
- Reset: gnt_valid=0, gnt_idx=0, gnt_onehot=0, ptr=0, FSM=IDLE. Takes effect at the clock edge with reset=1 and overrides every other event.
- Reset mid-grant: the outstanding grant is discarded with no handshake.
- Latency: req sampled at edge k in IDLE -> gnt_valid=1 after edge k (1 cycle).
- Handshake throughput: one grant per cycle while requests persist.
- gnt_ready while gnt_valid=0 is ignored.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- RR_ARB_LOCK_EN defined:
  - adds the lock input.
  - At a handshake with lock=1, if req[gnt_idx]=1, the next grant is the same gnt_idx and ptr is not advanced. This supports multi-beat ownership.
  - If req[gnt_idx]=0, lock is ignored and normal rotation applies.
- RR_ARB_LOCK_EN undefined: no lock port; rotation always applies.

## Structure
- Package arb_pkg: N_REQ, IDX_W, FSM state enum typedef (arb_state_t {IDLE, GRANT}).
- Sub-module prio_enc8_3: combinational.
  - Inputs: 8-bit vector.
  - Outputs: 3-bit index of the lowest set bit plus an any-set flag.
  - The top rotates req right by ptr, encodes it with prio_enc8_3, then adds ptr back mod 8.

## Test plan
- Reset, then req=8'h00 for 5 cycles -> gnt_valid=0, gnt_onehot=0, gnt_idx=0 throughout.
- req=8'b0001_0100, gnt_ready=1 constant, from ptr=0 -> grants alternate: idx 2, 4, 2, 4. gnt_valid stays high with no bubble.
- req=8'h80 asserted 1 cycle then dropped, gnt_ready=0 for 4 cycles then 1 -> gnt_idx=7 and gnt_onehot=8'h80 held all 4 cycles. After the handshake, gnt_valid=0 and ptr=0 (wrap).
- req=8'hFF, gnt_ready=1 for 9 cycles -> idx sequence 0,1,2,3,4,5,6,7,0.
- Grant on idx 3 pending, assert reset for 1 cycle -> next cycle gnt_valid=0, gnt_idx=0. With req=8'h08 held, the grant is idx 3 one cycle after reset is released.
- (RR_ARB_LOCK_EN) req=8'h03, lock=1, gnt_ready=1 -> idx 0 repeated. Set lock=0 -> next grant is idx 1.
